// File: rtl/golden_nonce_queue.sv
// Golden-nonce capture queue: first-word-fall-through FIFO of {tag, nonce} entries with
// saturating found/dropped statistics, read out over a valid/ready handshake.
module golden_nonce_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              hash_clk,
    input  logic              rst_n,
    input  logic              rx_new_nonce,
    input  logic [31:0]       rx_golden_nonce,
    input  logic [TAG_W-1:0]  rx_work_tag,
    output logic              tx_valid,
    output logic [31:0]       tx_nonce,
    output logic [TAG_W-1:0]  tx_tag,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   tx_level,
    output logic [CNT_W-1:0]  tx_found,
    output logic [CNT_W-1:0]  tx_dropped,
    input  logic              clear_stats
);

    localparam logic [ADDR_W:0]  LevelFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    logic [TAG_W+31:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [CNT_W-1:0]  found_q, found_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;

    logic full, pop, push, drop;

    always_comb begin
        full = (level_q == LevelFull);
        pop  = tx_valid && tx_ready;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push = rx_new_nonce && (!full || pop);
        drop = rx_new_nonce && full && !pop;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        found_d   = found_q;
        dropped_d = dropped_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        if (push && !pop) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end

        // Clear wins over any event counted in the same cycle.
        if (clear_stats) begin
            found_d   = '0;
            dropped_d = '0;
        end else begin
            if (push && (found_q != CntMax)) begin
                found_d = found_q + CNT_W'(1);
            end
            if (drop && (dropped_q != CntMax)) begin
                dropped_d = dropped_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            found_q   <= '0;
            dropped_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            found_q   <= found_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage needs no reset; an empty queue masks the head to zero.
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rx_work_tag, rx_golden_nonce};
        end
    end

    always_comb begin
        tx_valid   = (level_q != '0);
        tx_nonce   = '0;
        tx_tag     = '0;
        if (tx_valid) begin
            tx_nonce = mem_q[rd_ptr_q][31:0];
            tx_tag   = mem_q[rd_ptr_q][TAG_W+31:32];
        end
        tx_level   = level_q;
        tx_found   = found_q;
        tx_dropped = dropped_q;
    end

endmodule
